// File: rtl/ext_mem_loader_pkg.sv
// rtl/ext_mem_loader_pkg.sv - shared constants and state encoding for the program loader
package ext_mem_loader_pkg;

  localparam logic [7:0]  LOADER_MAGIC   = 8'hA5;
  // First IO address; the top-level decode uses the same boundary.
  localparam logic [31:0] IO_REGION_BASE = 32'h0300_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC,
    S_ADDR,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/ext_mem_loader.sv
// rtl/ext_mem_loader.sv - framed byte-stream loader driving the external data-memory write port
module ext_mem_loader
  import ext_mem_loader_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT     = IO_REGION_BASE,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_DataAdr,
  output logic [31:0] Ext_WriteData,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES - 1);

  loader_state_t r_state;
  logic [31:0]   r_addr;
  logic [15:0]   r_words;
  logic [23:0]   r_word;
  logic [7:0]    r_sum;
  logic [1:0]    r_byte_cnt;
  logic [TW-1:0] r_idle;

  logic          w_accept;
  logic          w_timed;
  logic          w_timeout;
  logic          w_bad_range;
  logic [15:0]   w_count;
  logic [31:0]   w_word;
  logic [33:0]   w_end;

  assign rx_ready  = r_state inside {S_SYNC, S_ADDR, S_COUNT, S_DATA, S_CHECK};
  assign busy      = rx_ready || (r_state == S_WRITE);
  assign w_accept  = rx_valid && rx_ready;
  assign w_timed   = r_state inside {S_ADDR, S_COUNT, S_DATA, S_CHECK};
  assign w_timeout = w_timed && !w_accept && (r_idle == IDLE_MAX);

  // Count and data words are completed combinationally from the byte on the bus.
  assign w_count     = {rx_data, r_words[15:8]};
  assign w_word      = {rx_data, r_word};
  assign w_end       = {2'b00, r_addr} + {16'b0, w_count, 2'b00};
  assign w_bad_range = (r_addr[1:0] != 2'b00) || (w_end > {2'b00, ADDR_LIMIT});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_words       <= '0;
      r_word        <= '0;
      r_sum         <= '0;
      r_byte_cnt    <= '0;
      r_idle        <= '0;
      Ext_MemWrite  <= 1'b0;
      Ext_DataAdr   <= '0;
      Ext_WriteData <= '0;
      cpu_reset     <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      Ext_MemWrite <= 1'b0;
      if (w_accept || !w_timed) r_idle <= '0;
      else                      r_idle <= r_idle + TW'(1);

      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state    <= S_SYNC;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_reset  <= 1'b1;
            r_sum      <= '0;
            r_byte_cnt <= '0;
            r_words    <= '0;
          end
        end
        S_SYNC: begin
          if (w_accept && rx_data == LOADER_MAGIC) r_state <= S_ADDR;
        end
        S_ADDR: begin
          if (w_accept) begin
            r_addr     <= {rx_data, r_addr[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state    <= S_COUNT;
              r_byte_cnt <= '0;
            end
          end
        end
        S_COUNT: begin
          if (w_accept) begin
            r_words    <= w_count;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd1) begin
              r_byte_cnt <= '0;
              if (w_bad_range) begin
                r_state <= S_ERR;
                error   <= 1'b1;
              end else if (w_count == 16'd0) begin
                r_state <= S_CHECK;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_word     <= {rx_data, r_word[23:8]};
            r_sum      <= r_sum + rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              Ext_MemWrite  <= 1'b1;
              Ext_DataAdr   <= r_addr;
              Ext_WriteData <= w_word;
              r_state       <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_addr  <= r_addr + 32'd4;
          r_words <= r_words - 16'd1;
          r_state <= (r_words == 16'd1) ? S_CHECK : S_DATA;
        end
        S_CHECK: begin
          if (w_accept) begin
            if (rx_data == r_sum) begin
              r_state   <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              r_state <= S_ERR;
              error   <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_timeout) begin
        r_state <= S_ERR;
        error   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ext_mem_loader.sv
// tb/tb_ext_mem_loader.sv - self-checking bench for ext_mem_loader against a frame-level model
module tb_ext_mem_loader;

  localparam int          TO    = 16;
  localparam logic [31:0] LIMIT = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        Ext_MemWrite;
  logic [31:0] Ext_DataAdr;
  logic [31:0] Ext_WriteData;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  ext_mem_loader #(.ADDR_LIMIT(LIMIT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .Ext_MemWrite(Ext_MemWrite), .Ext_DataAdr(Ext_DataAdr), .Ext_WriteData(Ext_WriteData),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] wr_q[$];
  logic [31:0] words[$];
  logic [7:0]  frame_q[$];

  always @(negedge clk) if (Ext_MemWrite === 1'b1) wr_q.push_back({Ext_DataAdr, Ext_WriteData});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int guard = 0;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
    ok = (rx_ready === 1'b1);
    if (ok) begin @(posedge clk); #1; end
    rx_valid = 1'b0;
  endtask

  task automatic build_frame(input int ngarb, input logic [31:0] addr, input logic [7:0] delta,
                             output logic [7:0] sum);
    logic [7:0]  g;
    logic [31:0] w;
    int          total = 0;
    frame_q.delete();
    for (int i = 0; i < ngarb; i++) begin
      if (i == 0)      g = 8'h00;
      else if (i == 1) g = 8'hFF;
      else if (i == 2) g = 8'h5A;
      else             g = 8'($urandom_range(255, 0));
      if (g == 8'hA5) g = 8'h3C;
      frame_q.push_back(g);
    end
    frame_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) frame_q.push_back(addr[8*i +: 8]);
    frame_q.push_back(8'(words.size() % 256));
    frame_q.push_back(8'(words.size() / 256));
    for (int k = 0; k < words.size(); k++) begin
      w = words[k];
      for (int i = 0; i < 4; i++) begin
        frame_q.push_back(w[8*i +: 8]);
        total += int'(w[8*i +: 8]);
      end
    end
    sum = 8'(total % 256);
    frame_q.push_back(sum + delta);
  endtask

  task automatic run_frame(input string tag, input int ngarb, input logic [31:0] addr,
                           input logic [7:0] delta, input int stall_pos, input int stall_len,
                           input int max_gap, input bit poke);
    logic [7:0] sum;
    int         acc = 0;
    int         n, hdr, exp_acc, exp_nw;
    bit         ok, exp_done, range_ok;
    n   = words.size();
    hdr = ngarb + 7;
    build_frame(ngarb, addr, delta, sum);
    wr_q.delete();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    check({tag, ":armed"}, 64'({busy, cpu_reset, done, error}), 64'(4'b1100));

    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i], (i == stall_pos) ? stall_len : $urandom_range(max_gap, 0), ok);
      if (!ok) break;
      acc++;
      if (poke && i == ngarb + 3) begin start = 1'b1; @(posedge clk); #1; start = 1'b0; end
    end

    range_ok = (addr[1:0] == 2'b00) && ({32'b0, addr} + 64'(4 * n) <= {32'b0, LIMIT});
    if (stall_len >= TO && stall_pos > ngarb) begin
      exp_acc  = stall_pos;
      exp_nw   = (stall_pos > hdr) ? (stall_pos - hdr) / 4 : 0;
      exp_done = 1'b0;
    end else if (!range_ok) begin
      exp_acc  = hdr;
      exp_nw   = 0;
      exp_done = 1'b0;
    end else begin
      exp_acc  = frame_q.size();
      exp_nw   = n;
      exp_done = (delta == 8'd0);
    end

    check({tag, ":accepted"}, 64'(acc), 64'(exp_acc));
    check({tag, ":status"}, 64'({done, error, cpu_reset, busy}),
          64'({exp_done, !exp_done, !exp_done, 1'b0}));
    repeat (2) @(posedge clk);
    #1;
    check({tag, ":nwrites"}, 64'(wr_q.size()), 64'(exp_nw));
    for (int i = 0; i < exp_nw && i < wr_q.size(); i++)
      check($sformatf("%s:wr%0d", tag, i), wr_q[i], {addr + 32'(4 * i), words[i]});
  endtask

  initial begin
    bit         ok;
    logic [7:0] sum;
    int         dpos;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #2;
    check("rst:ctl", 64'({rx_ready, Ext_MemWrite, cpu_reset, busy, done, error}), 64'(6'b001000));
    check("rst:adr", 64'(Ext_DataAdr), 64'd0);
    check("rst:wdata", 64'(Ext_WriteData), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    words = '{32'h11223344, 32'hAABBCCDD};
    run_frame("frameA", 0, 32'h0000_0100, 8'd0, -1, 0, 0, 1'b0);
    check("frameA:adr_hold", 64'(Ext_DataAdr), 64'h104);

    words = '{};
    run_frame("garbage_n0", 3, 32'h0000_0000, 8'd0, -1, 0, 1, 1'b0);

    words = '{32'hDEADBEEF};
    run_frame("bad_chk", 0, 32'h0000_0200, 8'd1, -1, 0, 1, 1'b0);

    words = '{32'h1, 32'h2};
    run_frame("over_limit", 0, 32'h02FF_FFFC, 8'd0, -1, 0, 0, 1'b0);
    words = '{32'h3};
    run_frame("misaligned", 0, 32'h0000_0102, 8'd0, -1, 0, 0, 1'b0);
    words = '{32'h5566_7788};
    run_frame("at_limit", 0, 32'h02FF_FFFC, 8'd0, -1, 0, 0, 1'b0);

    words = '{32'h0A0B0C0D, 32'h1A1B1C1D, 32'h2A2B2C2D};
    dpos = 7 + 4 + 2;
    run_frame("timeout16", 0, 32'h0000_0400, 8'd0, dpos, TO, 0, 1'b0);
    run_frame("stall15", 0, 32'h0000_0400, 8'd0, dpos, TO - 1, 0, 1'b0);

    words = '{32'hCAFE0001, 32'hCAFE0002};
    build_frame(0, 32'h0000_0300, 8'd0, sum);
    wr_q.delete();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 13; i++) send_byte(frame_q[i], 0, ok);
    check("midrst:one_write", 64'(wr_q.size()), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst:ctl", 64'({rx_ready, Ext_MemWrite, cpu_reset, busy, done, error}), 64'(6'b001000));
    check("midrst:adr", 64'(Ext_DataAdr), 64'd0);
    check("midrst:wdata", 64'(Ext_WriteData), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    run_frame("post_rst", 0, 32'h0000_0300, 8'd0, -1, 0, 1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      words.delete();
      repeat ($urandom_range(4, 0)) words.push_back($urandom);
      run_frame($sformatf("rand%0d", t), $urandom_range(4, 0),
                32'h0000_1000 + 32'(4 * $urandom_range(1023, 0)),
                ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'd0,
                -1, 0, 3, 1'($urandom_range(1, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
